xadac_exe_credit: RTL

XADAC_EXE_CREDIT -- requirements
Module: xadac_exe_credit

---
 rtl/xadac_exe_credit_if.sv | 31 +++
 rtl/xadac_exe_credit.sv | 74 +++++++
 2 files changed

// File: rtl/xadac_exe_credit_if.sv
// xadac_if: XADAC decode/execute channel bundle between core side and accelerator side
interface xadac_if #(
    parameter int DataW = 32
) ();
    logic [DataW-1:0] dec_req_data;
    logic             dec_req_valid;
    logic             dec_req_ready;
    logic [DataW-1:0] dec_rsp_data;
    logic             dec_rsp_valid;
    logic             dec_rsp_ready;
    logic [DataW-1:0] exe_req_data;
    logic             exe_req_valid;
    logic             exe_req_ready;
    logic [DataW-1:0] exe_rsp_data;
    logic             exe_rsp_valid;
    logic             exe_rsp_ready;

    modport slv (
        input  dec_req_data, dec_req_valid, output dec_req_ready,
        output dec_rsp_data, dec_rsp_valid, input  dec_rsp_ready,
        input  exe_req_data, exe_req_valid, output exe_req_ready,
        output exe_rsp_data, exe_rsp_valid, input  exe_rsp_ready
    );

    modport mst (
        output dec_req_data, dec_req_valid, input  dec_req_ready,
        input  dec_rsp_data, dec_rsp_valid, output dec_rsp_ready,
        output exe_req_data, exe_req_valid, input  exe_req_ready,
        input  exe_rsp_data, exe_rsp_valid, output exe_rsp_ready
    );
endinterface

// File: rtl/xadac_exe_credit.sv
// xadac_exe_credit: credit limiter and drain controller for the XADAC exe channel
module xadac_exe_credit #(
    parameter int MaxOutstanding = 4,
    parameter int CntW           = $clog2(MaxOutstanding + 1)
) (
    input  logic            clk,
    input  logic            rst,
    xadac_if.slv            slv,
    xadac_if.mst            mst,
    input  logic            drain_req,
    output logic            drain_done,
    output logic [CntW-1:0] outstanding,
    output logic            busy,
    output logic            err
);
    typedef enum logic {RUN, DRAIN} state_t;

    state_t state;
    logic   drain_pend;
    logic   allow;
    logic   req_hs;
    logic   rsp_hs;
    logic   stall;

    assign mst.dec_req_data  = slv.dec_req_data;
    assign mst.dec_req_valid = slv.dec_req_valid;
    assign slv.dec_req_ready = mst.dec_req_ready;
    assign slv.dec_rsp_data  = mst.dec_rsp_data;
    assign slv.dec_rsp_valid = mst.dec_rsp_valid;
    assign mst.dec_rsp_ready = slv.dec_rsp_ready;
    assign mst.exe_req_data  = slv.exe_req_data;
    assign slv.exe_rsp_data  = mst.exe_rsp_data;
    assign slv.exe_rsp_valid = mst.exe_rsp_valid;
    assign mst.exe_rsp_ready = slv.exe_rsp_ready;

    // allow is a function of registers only, so responses never feed the request path
    always_comb begin
        allow             = (state == RUN) && (outstanding != CntW'(MaxOutstanding));
        mst.exe_req_valid = slv.exe_req_valid && allow;
        slv.exe_req_ready = mst.exe_req_ready && allow;
        req_hs            = mst.exe_req_valid && mst.exe_req_ready;
        rsp_hs            = mst.exe_rsp_valid && slv.exe_rsp_ready;
        stall             = mst.exe_req_valid && !mst.exe_req_ready;
        drain_done        = (state == DRAIN) && (outstanding == '0);
        busy              = (outstanding != '0) || (state != RUN);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            state       <= RUN;
            drain_pend  <= 1'b0;
            err         <= 1'b0;
        end else begin
            if (req_hs && !rsp_hs) begin
                outstanding <= outstanding + CntW'(1);
            end else if (rsp_hs && !req_hs) begin
                if (outstanding == '0) err <= 1'b1;
                else outstanding <= outstanding - CntW'(1);
            end
            // a stalled request must complete before the exe channel closes
            if (state == RUN) begin
                if (drain_pend && !stall) begin
                    state      <= DRAIN;
                    drain_pend <= 1'b0;
                end else if (drain_req) begin
                    drain_pend <= 1'b1;
                end
            end else if (outstanding == '0) begin
                state <= RUN;
            end
        end
    end
endmodule
